// File: rtl/decoder_pkg.sv
// Shared types and helpers for the N-to-2^N decoder family.
// onehot() is sized for the widest supported select; callers truncate to their width.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/dec_dwell_timer.sv
// 8-bit down-counter with load, decrement and zero flag.
// Load wins over decrement; decrement stops at zero.
module dec_dwell_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != 8'd0)) begin
      cnt_reg <= cnt_reg - 8'd1;
    end
  end

  assign zero = (cnt_reg == 8'd0);

endmodule

// File: rtl/decoder_scan_nto2n.sv
// N-to-2^N one-hot decoder with registered outputs: direct decode of sel, or an
// autonomous scan that walks the one-hot line across all outputs with a fixed dwell.
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DWELL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               start,
  input  logic               cont,
  output logic [2**SEL_W-1:0] y,
  output logic               busy,
  output logic               done,
  output logic [SEL_W-1:0]   idx_o
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [7:0]     DWELL_LOAD = 8'(DWELL - 1);
  localparam logic [SEL_W:0] VISIT_ALL  = (SEL_W + 1)'(OUT_W);

  dec_state_t       state_reg, state_next;
  logic [SEL_W-1:0] idx_reg, idx_next, idx_inc;
  logic [OUT_W-1:0] y_reg, y_next, oh_sel, oh_inc;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             cont_reg, cont_next;
  logic [SEL_W:0]   visit_reg, visit_next;
  logic             timer_load, timer_dec, dwell_zero;
  logic             start_ok, last_line;

  assign idx_inc   = idx_reg + SEL_W'(1);
  assign oh_sel    = OUT_W'(onehot(MAX_SEL_W'(sel)));
  assign oh_inc    = OUT_W'(onehot(MAX_SEL_W'(idx_inc)));
  assign start_ok  = start && (mode == MODE_SCAN) && !en_n;
  // Only a non-continuous scan ever terminates on its own.
  assign last_line = (visit_reg == VISIT_ALL) && !cont_reg;

  dec_dwell_timer u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (DWELL_LOAD),
    .dec      (timer_dec),
    .zero     (dwell_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      y_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cont_reg  <= 1'b0;
      visit_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      y_reg     <= y_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      cont_reg  <= cont_next;
      visit_reg <= visit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = SCAN;
      SCAN:    if (en_n || (dwell_zero && last_line)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idx_next   = idx_reg;
    y_next     = y_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    cont_next  = cont_reg;
    visit_next = visit_reg;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_reg)
      IDLE: begin
        idx_next  = sel;
        busy_next = 1'b0;
        y_next    = (en_n || (mode == MODE_SCAN)) ? '0 : oh_sel;
        if (start_ok) begin
          y_next     = oh_sel;
          busy_next  = 1'b1;
          cont_next  = cont;
          visit_next = (SEL_W + 1)'(1);
          timer_load = 1'b1;
        end
      end
      SCAN: begin
        if (en_n) begin
          y_next    = '0;
          busy_next = 1'b0;
        end else if (!dwell_zero) begin
          timer_dec = 1'b1;
        end else if (last_line) begin
          y_next    = '0;
          busy_next = 1'b0;
          done_next = 1'b1;
        end else begin
          // Swap straight to the next line in one edge: no all-zero gap.
          idx_next   = idx_inc;
          y_next     = oh_inc;
          visit_next = visit_reg + (SEL_W + 1)'(1);
          timer_load = 1'b1;
        end
      end
      default: begin
        y_next    = '0;
        busy_next = 1'b0;
      end
    endcase
  end

  assign y     = y_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign idx_o = idx_reg;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Bench for decoder_scan_nto2n: two instances (DWELL=2 and DWELL=1) share stimulus and
// are compared every cycle against an arithmetic model of scan position versus time.
module tb_decoder_scan_nto2n;

  logic       clk = 1'b0;
  logic       rst_n, en_n, mode, start, cont;
  logic [2:0] sel;
  logic [7:0] y_o [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic [2:0] idx_w [2];

  int n_checks = 0;
  int n_fail   = 0;
  bit check_on = 0;

  always #5 clk = ~clk;

  decoder_scan_nto2n #(.SEL_W(3), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel), .start(start),
    .cont(cont), .y(y_o[0]), .busy(busy_o[0]), .done(done_o[0]), .idx_o(idx_w[0])
  );

  decoder_scan_nto2n #(.SEL_W(3), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel), .start(start),
    .cont(cont), .y(y_o[1]), .busy(busy_o[1]), .done(done_o[1]), .idx_o(idx_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a scan is described only by its start line and elapsed cycles.
  int   dw [2] = '{2, 1};
  bit   m_busy [2], m_cont [2], m_done [2], m_valid [2];
  int   m_el [2], m_st [2], m_idx [2];
  logic [7:0] m_y [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_done[i] = 0; m_y[i] = '0; m_idx[i] = 0; m_valid[i] = 1;
        m_cont[i] = 0; m_el[i] = 0; m_st[i] = 0;
      end else if (!m_busy[i]) begin
        m_done[i]  = 0;
        m_idx[i]   = int'(sel);
        m_valid[i] = !mode;
        m_y[i]     = (en_n || mode) ? 8'h00 : (8'h01 << sel);
        if (start && mode && !en_n) begin
          m_busy[i] = 1; m_st[i] = int'(sel); m_cont[i] = cont; m_el[i] = 0;
          m_y[i] = 8'h01 << sel; m_valid[i] = 1;
        end
      end else if (en_n) begin
        m_busy[i] = 0; m_y[i] = '0; m_done[i] = 0; m_valid[i] = 0;
      end else begin
        m_el[i]++;
        if (!m_cont[i] && m_el[i] == 8 * dw[i]) begin
          m_busy[i] = 0; m_y[i] = '0; m_done[i] = 1; m_valid[i] = 0;
        end else begin
          m_idx[i] = (m_st[i] + m_el[i] / dw[i]) % 8;
          m_y[i]   = 8'h01 << m_idx[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("y%0d", i), 32'(y_o[i]), 32'(m_y[i]));
        check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_busy[i]));
        check($sformatf("done%0d", i), 32'(done_o[i]), 32'(m_done[i]));
        check($sformatf("onehot0_%0d", i), 32'($onehot0(y_o[i])), 32'd1);
        if (m_valid[i]) check($sformatf("idx%0d", i), 32'(idx_w[i]), 32'(m_idx[i]));
      end
    end
  end

  task automatic pulse_start(input logic [2:0] s, input logic c);
    mode = 1'b1; sel = s; cont = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int hi, dn, k;
    bit seen;
    rst_n = 1'b0; en_n = 1'b1; mode = 1'b0; start = 1'b0; cont = 1'b0; sel = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_y", 32'(y_o[i]), 0);
      check("rst_busy", 32'(busy_o[i]), 0);
      check("rst_done", 32'(done_o[i]), 0);
      check("rst_idx", 32'(idx_w[i]), 0);
    end
    rst_n = 1'b1;
    check_on = 1;

    // 1: direct decode, then disable
    $display("txn 1: DIRECT sel=5 then en_n=1");
    en_n = 1'b0; mode = 1'b0; sel = 3'd5;
    @(negedge clk);
    check("direct_y", 32'(y_o[0]), 32'h20);
    check("direct_idx", 32'(idx_w[0]), 5);
    en_n = 1'b1;
    @(negedge clk);
    check("disabled_y", 32'(y_o[0]), 0);
    en_n = 1'b0; mode = 1'b1;
    @(negedge clk);

    // 2: single scan from line 6
    $display("txn 2: SCAN sel=6 cont=0");
    pulse_start(3'd6, 1'b0);
    check("scan2_first", 32'(y_o[0]), 32'h40);
    hi = 1; dn = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (y_o[0] != 0) hi++;
      if (done_o[0]) begin dn++; seen = 1; end
    end
    check("scan2_timeout", 32'(seen), 1);
    repeat (2) begin
      @(negedge clk);
      if (done_o[0]) dn++;
    end
    check("scan2_high_cycles", 32'(hi), 16);
    check("scan2_done_pulses", 32'(dn), 1);

    // 3: continuous scan wraps, then aborts
    $display("txn 3: SCAN sel=0 cont=1, abort at cycle 20");
    pulse_start(3'd0, 1'b1);
    dn = 0;
    for (k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (done_o[0]) dn++;
      if (k == 17) check("scan3_wrap", 32'(y_o[0]), 32'h01);
    end
    check("scan3_no_done", 32'(dn), 0);
    en_n = 1'b1;
    @(negedge clk);
    check("abort_y", 32'(y_o[0]), 0);
    check("abort_busy", 32'(busy_o[0]), 0);
    check("abort_done", 32'(done_o[0]), 0);
    en_n = 1'b0;
    @(negedge clk);

    // 4: start while busy is ignored
    $display("txn 4: SCAN sel=1, restart with sel=3 mid-scan");
    pulse_start(3'd1, 1'b0);
    repeat (4) @(negedge clk);
    pulse_start(3'd3, 1'b0);
    check("scan4_busy", 32'(busy_o[0]), 1);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done_o[0]) seen = 1;
    end
    check("scan4_timeout", 32'(seen), 1);
    @(negedge clk);

    // 5: asynchronous reset mid-scan
    $display("txn 5: reset while on line 4");
    pulse_start(3'd4, 1'b0);
    check("scan5_line4", 32'(y_o[0]), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_y", 32'(y_o[0]), 0);
    check("async_rst_busy", 32'(busy_o[0]), 0);
    check("async_rst_done", 32'(done_o[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_y", 32'(y_o[0]), 0);
    check("post_rst_busy", 32'(busy_o[0]), 0);

    // 6: DWELL=1 instance, restart in the done cycle
    $display("txn 6: DWELL=1 SCAN sel=7, restart on done");
    pulse_start(3'd7, 1'b0);
    k = 1; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      k++;
      if (done_o[1]) seen = 1;
    end
    check("scan6_done_cycle", 32'(k), 9);
    mode = 1'b1; sel = 3'd2; cont = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("scan6_restart_y", 32'(y_o[1]), 32'h04);
    check("scan6_restart_busy", 32'(busy_o[1]), 1);
    repeat (20) @(negedge clk);

    // Random phase
    $display("txn 7: randomized stimulus, 3000 cycles");
    for (int c = 0; c < 3000; c++) begin
      en_n  = ($urandom_range(0, 39) == 0);
      mode  = 1'($urandom_range(0, 1));
      sel   = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 5) == 0);
      cont  = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end

    check_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
